csa_triple_collector: RTL and testbench
=======================================

CSA_TRIPLE_COLLECTOR -- requirements
Module: csa_triple_collector

Interface
REQ-001 Parameters: none. Operand width SHALL be fixed at 4 bits; result width SHALL be fixed at 6 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream operand valid.
REQ-005 in_ready  output  1  block can accept an operand this cycle.
REQ-006 in_data  input  4  unsigned operand.
REQ-007 out_valid  output  1  triple sum available.
REQ-008 out_ready  input  1  downstream accepts the sum.
REQ-009 out_sum  output  6  exact unsigned sum A+B+C, range 0..45.
REQ-010 flush  input  1  close a partial triple; present only with CSA_COLLECT_FLUSH_EN.

Function
REQ-011 An operand SHALL be accepted on a rising edge where in_valid and in_ready are both high; accepted operands SHALL fill slots A, B and C in order.
REQ-012 The FSM SHALL have states EMPTY (0 held), ONE (A held), TWO (A,B held) and FULL (A,B,C held, result pending).
REQ-013 Transitions: EMPTY->ONE, ONE->TWO and TWO->FULL on accept; otherwise hold.
REQ-014 in_ready SHALL be 1 in EMPTY, ONE and TWO; in FULL it SHALL equal out_ready.
REQ-015 out_valid SHALL be 1 only in FULL; out_sum SHALL be held stable while out_valid=1 and out_ready=0.
REQ-016 Latency: out_valid SHALL rise in the cycle immediately after the edge accepting the third operand.
REQ-017 In FULL, out_ready=1 with in_valid=0 SHALL go to EMPTY; out_ready=1 with in_valid=1 SHALL complete the output handshake, load the new operand into A and go to ONE on the same edge, with no bubble.
REQ-018 out_sum SHALL be computed combinationally from the A/B/C registers through a 3:2 compression row followed by a carry-propagate add; the top carry (bit 5) SHALL NOT be dropped.
REQ-019 Outside FULL, out_sum SHALL read as 0.
REQ-020 in_data SHALL be ignored on cycles with no accept.

Reset
REQ-021 While rst=1 the state SHALL be EMPTY, A/B/C SHALL be 0, out_valid SHALL be 0, in_ready SHALL be 1 and out_sum SHALL be 0.
REQ-022 rst asserted mid-triple or in FULL SHALL discard held operands and any pending result immediately, without waiting for a clock edge.
REQ-023 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-024 Macro CSA_COLLECT_FLUSH_EN: when defined, the flush port SHALL exist; when undefined, the port SHALL be absent and the behaviour SHALL equal flush=0.
REQ-025 flush=1 in ONE or TWO SHALL zero the unfilled slots and go to FULL on that edge.
REQ-026 flush=1 in EMPTY or FULL SHALL have no effect.
REQ-027 flush=1 with an accept in the same cycle SHALL include the accepted operand first and zero only the slots still empty; an accept in TWO with flush SHALL behave as a plain accept.

Structure
REQ-028 The shared package csa_pkg SHALL hold OPW=4, SUMW=6 and the FSM state enum (EMPTY, ONE, TWO, FULL).
REQ-029 One sub-module, csa_compress, SHALL implement the combinational 3:2 row plus final add for 4-bit inputs and a 6-bit output; csa_triple_collector SHALL instantiate it once.

Verification
REQ-030 After reset, push 3, 5, 7 back-to-back with out_ready=1 -> out_valid one cycle after the third accept, out_sum=15.
REQ-031 Push 15, 15, 15 -> out_sum=45 (6'b101101), confirming bit 5 is kept.
REQ-032 Complete a triple 1, 2, 3 with out_ready=0 for 4 cycles -> out_sum=6 held stable, in_ready=0; then raise out_ready with in_valid=1, data 9 -> handshake completes on one edge, state ONE, A=9.
REQ-033 Push 4, 4, then assert rst between edges -> out_valid=0 and in_ready=1 immediately; then push 1, 1, 1 -> out_sum=3.
REQ-034 With CSA_COLLECT_FLUSH_EN: push 6 then pulse flush -> out_sum=6; push 2 together with flush -> out_sum=2; flush in EMPTY -> no out_valid.
REQ-035 Random stream of 300 operands with random in_valid/out_ready stalls -> every result equals the reference sum of its triple, in order, with none lost or duplicated.

Source files
------------

// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the triple collector: operand and result widths and
// the collector FSM state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package csa_pkg;

    localparam int OPW  = 4;    // operand width
    localparam int SUMW = 6;    // result width, 3 * 15 = 45 needs 6 bits

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        FULL  = 2'd3
    } csa_state_t;

endpackage

// File: rtl/csa_triple_collector_if.sv
// -----------------------------------------------------------------------------
// csa_triple_collector_if
// Operand input handshake and sum output handshake of the triple collector.
// Signals:
//   in_valid / in_ready / in_data    : operand stream into the collector
//   out_valid / out_ready / out_sum  : triple-sum stream out of the collector
// Modports:
//   master : drives operands, consumes sums (testbench / upstream logic)
//   slave  : the collector itself
// -----------------------------------------------------------------------------
interface csa_triple_collector_if;
    import csa_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  in_data;
    logic            out_valid;
    logic            out_ready;
    logic [SUMW-1:0] out_sum;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum
    );

endinterface

// File: rtl/csa_compress.sv
// -----------------------------------------------------------------------------
// csa_compress
// Combinational three-operand adder: one 3:2 carry-save row followed by a
// carry-propagate add. The top carry is kept, so the full 0..45 range fits.
// Ports:
//   i_a, i_b, i_c : 4-bit unsigned operands
//   o_sum         : 6-bit exact sum
// -----------------------------------------------------------------------------
module csa_compress
    import csa_pkg::*;
(
    input  logic [OPW-1:0]  i_a,
    input  logic [OPW-1:0]  i_b,
    input  logic [OPW-1:0]  i_c,
    output logic [SUMW-1:0] o_sum
);

    logic [OPW-1:0] w_s;
    logic [OPW-1:0] w_cy;

    assign w_s  = i_a ^ i_b ^ i_c;
    assign w_cy = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

    // Carry vector carries weight 2, hence the one-bit left shift.
    assign o_sum = {2'b00, w_s} + {1'b0, w_cy, 1'b0};

endmodule

// File: rtl/csa_triple_collector.sv
// -----------------------------------------------------------------------------
// csa_triple_collector
// Collects three operands (slots A, B, C) from a valid/ready stream and
// presents their exact sum on a valid/ready output. A new operand can be
// accepted on the same edge that the pending sum is handed off.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : csa_triple_collector_if.slave (operand in, sum out)
//   flush : close a partial triple, zero-filling empty slots
//           (present only when CSA_COLLECT_FLUSH_EN is defined)
// Configuration macro: CSA_COLLECT_FLUSH_EN
//
// state | meaning
// EMPTY | no operand held
// ONE   | A held
// TWO   | A, B held
// FULL  | A, B, C held, sum pending on output
// -----------------------------------------------------------------------------
module csa_triple_collector
    import csa_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
`ifdef CSA_COLLECT_FLUSH_EN
    input  logic                  flush,
`endif
    csa_triple_collector_if.slave bus
);

    csa_state_t      r_state;
    logic            r_out_valid;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic [OPW-1:0]  r_c;
    logic            w_flush;
    logic            w_acc;
    logic [SUMW-1:0] w_sum;

`ifdef CSA_COLLECT_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // In FULL the slot frees up only when the sum leaves on the same edge.
    assign bus.in_ready  = (r_state != FULL) || bus.out_ready;
    assign w_acc         = bus.in_valid && bus.in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_valid ? w_sum : '0;

    csa_compress u_compress (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_c   (r_c),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        r_a <= bus.in_data;
                        if (w_flush) begin
                            r_b         <= '0;
                            r_c         <= '0;
                            r_state     <= FULL;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ONE;
                        end
                    end
                end
                ONE: begin
                    if (w_acc) begin
                        r_b <= bus.in_data;
                        if (w_flush) begin
                            r_c         <= '0;
                            r_state     <= FULL;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= TWO;
                        end
                    end else if (w_flush) begin
                        r_b         <= '0;
                        r_c         <= '0;
                        r_state     <= FULL;
                        r_out_valid <= 1'b1;
                    end
                end
                TWO: begin
                    if (w_acc || w_flush) begin
                        r_c         <= w_acc ? bus.in_data : '0;
                        r_state     <= FULL;
                        r_out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (bus.in_valid) begin
                            r_a     <= bus.in_data;
                            r_state <= ONE;
                        end else begin
                            r_state <= EMPTY;
                        end
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_triple_collector.sv
// -----------------------------------------------------------------------------
// tb_csa_triple_collector
// Directed and randomized checks of the triple collector. Flush scenarios are
// compiled in when CSA_COLLECT_FLUSH_EN is defined.
// -----------------------------------------------------------------------------
module tb_csa_triple_collector;
    import csa_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   n_tests;
    int   n_fail;

    csa_triple_collector_if bus ();

    csa_triple_collector dut (
        .clk   (clk),
        .rst   (rst),
`ifdef CSA_COLLECT_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        tick();
    endtask

    initial begin
        int acc_cnt;
        int res_cnt;
        int cyc;
        int tn;
        int tsum;
        int exp_q[$];

        n_tests = 0;
        n_fail  = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_sum", bus.out_sum, 0);

        // 3 + 5 + 7, first accept on the first edge after reset release
        #10 rst = 1'b0;
        push(4'd3);
        chk("t1_valid_after_1", bus.out_valid, 0);
        push(4'd5);
        chk("t1_valid_after_2", bus.out_valid, 0);
        chk("t1_sum_partial", bus.out_sum, 0);
        push(4'd7);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_sum", bus.out_sum, 15);
        chk("t1_in_ready_full", bus.in_ready, 1);
        drain();
        chk("t1_drained_valid", bus.out_valid, 0);
        chk("t1_drained_sum", bus.out_sum, 0);

        // Maximum sum keeps bit 5
        push(4'd15);
        push(4'd15);
        push(4'd15);
        chk("t2_sum_max", bus.out_sum, 45);
        drain();

        // Backpressure then no-bubble handoff
        bus.out_ready = 1'b0;
        push(4'd1);
        push(4'd2);
        push(4'd3);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd13;
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_sum", bus.out_sum, 6);
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.in_data   = 4'd9;
        bus.out_ready = 1'b1;
        #1;
        chk("t3_in_ready_release", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("t3_after_handoff_valid", bus.out_valid, 0);
        push(4'd1);
        push(4'd1);
        chk("t3_a_was_9", bus.out_sum, 11);
        drain();

        // Asynchronous reset mid-triple
        push(4'd4);
        push(4'd4);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_valid", bus.out_valid, 0);
        chk("t4_rst_in_ready", bus.in_ready, 1);
        #1 rst = 1'b0;
        push(4'd1);
        push(4'd1);
        push(4'd1);
        chk("t4_sum_after_rst", bus.out_sum, 3);
        drain();

        // Asynchronous reset with a pending result
        bus.out_ready = 1'b0;
        push(4'd8);
        push(4'd8);
        push(4'd8);
        chk("t5_pending_sum", bus.out_sum, 24);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", bus.out_valid, 0);
        chk("t5_rst_in_ready", bus.in_ready, 1);
        chk("t5_rst_sum", bus.out_sum, 0);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        push(4'd2);
        push(4'd0);
        push(4'd5);
        chk("t5_sum_after_rst", bus.out_sum, 7);
        drain();

`ifdef CSA_COLLECT_FLUSH_EN
        push(4'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("f1_valid", bus.out_valid, 1);
        chk("f1_sum", bus.out_sum, 6);
        drain();
        flush = 1'b1;
        push(4'd2);
        flush = 1'b0;
        chk("f2_valid", bus.out_valid, 1);
        chk("f2_sum", bus.out_sum, 2);
        drain();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("f3_empty_valid", bus.out_valid, 0);
        push(4'd3);
        push(4'd4);
        flush = 1'b1;
        push(4'd5);
        flush = 1'b0;
        chk("f4_two_accept_sum", bus.out_sum, 12);
        drain();
`endif

        // Random stream with stalls on both sides
        acc_cnt = 0;
        res_cnt = 0;
        cyc     = 0;
        tn      = 0;
        tsum    = 0;
        while ((acc_cnt < 300 || exp_q.size() > 0 || bus.out_valid) && cyc < 5000) begin
            bus.in_valid  = (acc_cnt < 300) && ($urandom_range(0, 9) < 7);
            bus.in_data   = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 9) < 6);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                res_cnt++;
                if (exp_q.size() > 0)
                    chk("rand_sum", bus.out_sum, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cnt++;
                tsum += int'(bus.in_data);
                tn++;
                if (tn == 3) begin
                    exp_q.push_back(tsum);
                    tn   = 0;
                    tsum = 0;
                end
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("rand_budget", int'(cyc < 5000), 1);
        chk("rand_accepts", acc_cnt, 300);
        chk("rand_results", res_cnt, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
